sample_stream_ctrl: RTL and testbench
=====================================

# sample_stream_ctrl

Sequences the 3-byte-to-24-bit sample packing buffer (`accumulator`) between the SD-card block reader and the sample-rate playback path. It:
- fetches consecutive 512-byte blocks from the SD reader;
- paces byte writes so the buffer never drops a byte;
- issues buffer reads only when a packed word is committed, on each `sample_tick`.

It owns the buffer's reset, fill accounting and underrun reporting.

## Interface
- `BLOCK_BYTES`, 512, bytes per SD block.
- `DEPTH`, 512, buffer depth in 24-bit words; must equal the buffer's RAM depth.
- `LOW_WATER`, 320, a new block is requested when committed words ≤ this; requires `LOW_WATER + 172 < DEPTH`.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse: flush buffer, begin playback of `num_blocks` from `start_block`.
- `stop`  in  1  pulse: abort to `IDLE`, flush buffer.
- `start_block`  in  32  first block address, sampled on `start`.
- `num_blocks`  in  32  block count, sampled on `start`.
- `sample_tick`  in  1  one-cycle sample-rate strobe.
- `sd_rd_req`  out  1  block read request, held until `sd_rd_ack`.
- `sd_rd_addr`  out  32  block address, stable while `sd_rd_req` is high.
- `sd_rd_ack`  in  1  request accepted.
- `sd_byte_valid`  in  1  byte available.
- `sd_byte`  in  8  byte data.
- `sd_byte_ready`  out  1  byte accepted when valid & ready.
- `sd_rd_done`  in  1  pulse after the last byte of a block.
- `acc_resetn`  out  1  buffer reset; equals `resetn` & ~flush.
- `acc_wr_en`  out  1  equals `sd_byte_valid & sd_byte_ready`.
- `acc_data`  out  8  equals `sd_byte`.
- `acc_rd`  out  1  buffer read strobe.
- `acc_data_out`  in  24  buffer read data.
- `sample_valid`  out  1  one-cycle strobe.
- `sample_hi`, `sample_lo`  out  12 each  `acc_data_out[23:12]` / `[11:0]`.
- `busy`, `done`  out  1 each  status; `done` is a one-cycle pulse.
- `underrun_cnt`  out  16  saturating count of missed ticks.
- `fill_words`  out  10  committed, unread words.

## Operation
- **FSM states:** `IDLE`, `FLUSH`, `REQ`, `XFER`, `WAIT`, `DRAIN`.
- **Start:** `IDLE` + `start` → `FLUSH`. `FLUSH` lasts one cycle with `acc_resetn` = 0 and clears the fill, phase and tick state. It then goes to `REQ`, or to `DRAIN` if `num_blocks` = 0.
- **Block fetch:** `REQ` raises `sd_rd_req` with `sd_rd_addr` = `start_block` + `blk_idx`. On `sd_rd_ack` → `XFER`. `XFER` + `sd_rd_done` increments `blk_idx`, then:
  - → `DRAIN` if `blk_idx` reaches `num_blocks`;
  - else → `REQ` if `fill_words` ≤ `LOW_WATER`;
  - else → `WAIT`.
- `WAIT` → `REQ` when `fill_words` ≤ `LOW_WATER`.
- **Completion:** `DRAIN` → `IDLE` with a `done` pulse when `fill_words` = 0 and no read is in flight. Residual bytes (total bytes mod 3) are discarded.
- **Stop:** `stop` in any non-`IDLE` state forces one flush cycle, then `IDLE`, with no `done` pulse. `stop` takes priority over `start`. A `start` while busy is ignored.
- **Byte phase:** a mod-3 counter advances on each accepted byte and persists across block boundaries. It is cleared only by flush.
- **Gap rule:** `sd_byte_ready` = 0 in the cycle after each third byte. The buffer commits its word in that cycle, and a write there would corrupt its byte count.
- **Read arbitration:** `sample_tick` sets `tick_pend`. `rd_slot` = `tick_pend` & (`fill_words` ≠ 0), and `acc_rd` = `rd_slot`. `sd_byte_ready` = (state = `XFER`) & ~gap & ~`rd_slot`, so reads beat writes and are never simultaneous with them.
- **Read completion:** `acc_rd` clears `tick_pend` and decrements `fill_words`.
- **Underrun:** a `sample_tick` arriving while `tick_pend` is already set counts as an underrun and keeps `tick_pend` set. `acc_rd` is never issued with `fill_words` = 0. An empty read would rewind the buffer's read pointer.
- **Fill accounting:** `fill_words` increments one cycle after each third byte, at the end of the gap cycle. Simultaneous increment and decrement leave it unchanged.

## Timing
- **Reset values:** all outputs 0 except `acc_resetn` (follows `resetn`) and `sample_hi`/`lo` (0). State = `IDLE`.
- **Write-to-read:** third byte accepted in cycle N → gap in N+1 → word readable by `acc_rd` in N+2.
- **Read latency:** `acc_rd` in cycle M → `acc_data_out` valid in M+1, registered → `sample_valid` plus data in M+2.
- **Tick latency:** with data available and no read in flight, `acc_rd` is issued in the cycle after `sample_tick`.
- **Request timing:** `sd_rd_req` is asserted the cycle after entering `REQ` and deasserted the cycle after `sd_rd_ack`.
- **Stop mid-transfer:** the SD reader must tolerate `sd_byte_ready` = 0 indefinitely.

## Structure
- **Package `sample_stream_pkg`:**
  - state enum;
  - `BLOCK_BYTES`;
  - `MAX_WORDS_PER_BLK` = 171;
  - `UNDERRUN_W` = 16.
- **Sub-module `fill_tracker`:** owns the byte phase, gap generation, delayed commit, `fill_words` and `tick_pend`/underrun logic. The top level holds the FSM and SD handshake.

## Test plan
- **Single block:** `start_block` = 0x100, `num_blocks` = 1, 512 bytes 0x00..0xFF. Required:
  - `sd_rd_addr` = 0x100;
  - 170 words committed;
  - first sample `hi` = 0x000, `lo` = 0x102 from bytes 00,01,02;
  - `done` after 170 reads.
- **Gap rule:** continuous `sd_byte_valid`. Required: `sd_byte_ready` low exactly every 4th cycle; `fill_words` rises 1 per 4 cycles.
- **Tick and byte collision:** `sample_tick` mid-stream with `fill_words` = 5. Required: `acc_rd` high with `sd_byte_ready` low the next cycle; `sample_valid` 2 cycles later.
- **Underrun:** ticks every 2 cycles while the SD source stalls. Required: `underrun_cnt` increments; `acc_rd` never high with `fill_words` = 0.
- **Low water:** `num_blocks` = 4, ticks off. Required: `WAIT` entered once `fill_words` > 320; re-request after ticks drain `fill_words` to 320; 682 words total.
- **Stop mid-XFER:** `stop` at byte 200. Required: `acc_resetn` low 1 cycle; `IDLE`; `fill_words` = 0; no `done` pulse.

Source files
------------

// File: rtl/sample_stream_pkg.sv
// Shared types and constants for the SD-to-playback sample streaming controller.
package sample_stream_pkg;

    localparam int unsigned BLOCK_BYTES       = 512;
    localparam int unsigned MAX_WORDS_PER_BLK = 171;
    localparam int unsigned UNDERRUN_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        REQ,
        XFER,
        WAIT,
        DRAIN
    } state_t;

endpackage

// File: rtl/sample_stream_ctrl_fill.sv
// Byte-phase tracking, gap generation, committed-word fill count and tick/underrun
// bookkeeping for the 3-byte packing buffer.
module fill_tracker
    import sample_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  byte_acc,
    input  logic                  sample_tick,
    output logic                  gap,
    output logic                  rd_slot,
    output logic [9:0]            fill_words,
    output logic [UNDERRUN_W-1:0] underrun_cnt
);

    logic [1:0] phase;
    logic       tick_pend;
    logic       inc;

    // Reads are suppressed during flush so no sample escapes an aborted run.
    assign rd_slot = tick_pend & (fill_words != '0) & ~flush;
    assign inc     = gap & (fill_words != 10'(DEPTH));

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            phase        <= '0;
            gap          <= 1'b0;
            tick_pend    <= 1'b0;
            fill_words   <= '0;
            underrun_cnt <= '0;
        end else begin
            gap <= 1'b0;
            if (byte_acc) begin
                if (phase == 2'd2) begin
                    phase <= '0;
                    gap   <= 1'b1;
                end else begin
                    phase <= phase + 2'd1;
                end
            end

            if (sample_tick)
                tick_pend <= 1'b1;
            else if (rd_slot)
                tick_pend <= 1'b0;

            if (sample_tick && tick_pend && (underrun_cnt != '1))
                underrun_cnt <= underrun_cnt + UNDERRUN_W'(1);

            // The buffer commits its word during the gap cycle; count it at the end of that cycle.
            unique case ({inc, rd_slot})
                2'b10:   fill_words <= fill_words + 10'd1;
                2'b01:   fill_words <= fill_words - 10'd1;
                default: fill_words <= fill_words;
            endcase
        end
    end

endmodule

// File: rtl/sample_stream_ctrl.sv
// Block-fetch sequencer between the SD block reader and the 24-bit sample packing
// buffer; owns buffer reset, write pacing and sample-rate read issue.
module sample_stream_ctrl #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned LOW_WATER   = 320
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic [31:0]                          start_block,
    input  logic [31:0]                          num_blocks,
    input  logic                                 sample_tick,
    output logic                                 sd_rd_req,
    output logic [31:0]                          sd_rd_addr,
    input  logic                                 sd_rd_ack,
    input  logic                                 sd_byte_valid,
    input  logic [7:0]                           sd_byte,
    output logic                                 sd_byte_ready,
    input  logic                                 sd_rd_done,
    output logic                                 acc_resetn,
    output logic                                 acc_wr_en,
    output logic [7:0]                           acc_data,
    output logic                                 acc_rd,
    input  logic [23:0]                          acc_data_out,
    output logic                                 sample_valid,
    output logic [11:0]                          sample_hi,
    output logic [11:0]                          sample_lo,
    output logic                                 busy,
    output logic                                 done,
    output logic [sample_stream_pkg::UNDERRUN_W-1:0] underrun_cnt,
    output logic [9:0]                           fill_words
);

    import sample_stream_pkg::*;

    localparam int unsigned BC_W = $clog2(BLOCK_BYTES + 1);

    state_t          state;
    logic            aborting;
    logic [31:0]     base_blk;
    logic [31:0]     nblk;
    logic [31:0]     blk_idx;
    logic [BC_W-1:0] blk_bytes;
    logic            flush;
    logic            gap;
    logic            rd_slot;
    logic            rd_d1;
    logic            fill_low;
    logic            blk_room;

    assign flush      = (state == FLUSH);
    assign acc_resetn = resetn & ~flush;
    assign fill_low   = (fill_words <= 10'(LOW_WATER));
    // Never take more than one block's worth of bytes per request.
    assign blk_room   = (blk_bytes != BC_W'(BLOCK_BYTES));

    assign sd_byte_ready = (state == XFER) & ~gap & ~rd_slot & blk_room;
    assign acc_wr_en     = sd_byte_valid & sd_byte_ready;
    assign acc_data      = sd_byte;
    assign acc_rd        = rd_slot;

    fill_tracker #(
        .DEPTH(DEPTH)
    ) u_fill (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .byte_acc     (acc_wr_en),
        .sample_tick  (sample_tick),
        .gap          (gap),
        .rd_slot      (rd_slot),
        .fill_words   (fill_words),
        .underrun_cnt (underrun_cnt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            aborting   <= 1'b0;
            base_blk   <= '0;
            nblk       <= '0;
            blk_idx    <= '0;
            blk_bytes  <= '0;
            sd_rd_req  <= 1'b0;
            sd_rd_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (acc_wr_en)
                blk_bytes <= blk_bytes + BC_W'(1);

            if (stop && (state != IDLE)) begin
                state     <= FLUSH;
                aborting  <= 1'b1;
                sd_rd_req <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state    <= FLUSH;
                            aborting <= 1'b0;
                            base_blk <= start_block;
                            nblk     <= num_blocks;
                            blk_idx  <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (aborting) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (nblk == '0) begin
                            state <= DRAIN;
                        end else begin
                            state <= REQ;
                        end
                    end
                    // Request rises one cycle into REQ, with its address, and drops after the ack.
                    REQ: begin
                        if (!sd_rd_req) begin
                            sd_rd_req  <= 1'b1;
                            sd_rd_addr <= base_blk + blk_idx;
                        end else if (sd_rd_ack) begin
                            sd_rd_req <= 1'b0;
                            blk_bytes <= '0;
                            state     <= XFER;
                        end
                    end
                    XFER: begin
                        if (sd_rd_done) begin
                            blk_idx <= blk_idx + 32'd1;
                            if ((blk_idx + 32'd1) == nblk)
                                state <= DRAIN;
                            else if (fill_low)
                                state <= REQ;
                            else
                                state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (fill_low)
                            state <= REQ;
                    end
                    DRAIN: begin
                        if ((fill_words == '0) && !gap && !rd_slot && !rd_d1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            rd_d1        <= 1'b0;
            sample_valid <= 1'b0;
            sample_hi    <= '0;
            sample_lo    <= '0;
        end else begin
            rd_d1        <= rd_slot;
            sample_valid <= rd_d1;
            if (rd_d1) begin
                sample_hi <= acc_data_out[23:12];
                sample_lo <= acc_data_out[11:0];
            end
        end
    end

endmodule

// File: tb/tb_sample_stream_ctrl.sv
// Directed bench for sample_stream_ctrl with behavioural SD reader and packing buffer.
module tb_sample_stream_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0, start = 1'b0, stop = 1'b0, sample_tick = 1'b0;
    logic [31:0] start_block = '0, num_blocks = '0;
    logic        sd_rd_req, sd_rd_ack = 1'b0, sd_byte_valid = 1'b0, sd_rd_done = 1'b0;
    logic [31:0] sd_rd_addr;
    logic [7:0]  sd_byte = '0, acc_data;
    logic        sd_byte_ready, acc_resetn, acc_wr_en, acc_rd;
    logic [23:0] acc_data_out = '0;
    logic        sample_valid, busy, done;
    logic [11:0] sample_hi, sample_lo;
    logic [15:0] underrun_cnt;
    logic [9:0]  fill_words;

    always #5 clk = ~clk;

    sample_stream_ctrl #(
        .BLOCK_BYTES(512),
        .DEPTH      (512),
        .LOW_WATER  (320)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop),
        .start_block(start_block), .num_blocks(num_blocks), .sample_tick(sample_tick),
        .sd_rd_req(sd_rd_req), .sd_rd_addr(sd_rd_addr), .sd_rd_ack(sd_rd_ack),
        .sd_byte_valid(sd_byte_valid), .sd_byte(sd_byte), .sd_byte_ready(sd_byte_ready),
        .sd_rd_done(sd_rd_done), .acc_resetn(acc_resetn), .acc_wr_en(acc_wr_en),
        .acc_data(acc_data), .acc_rd(acc_rd), .acc_data_out(acc_data_out),
        .sample_valid(sample_valid), .sample_hi(sample_hi), .sample_lo(sample_lo),
        .busy(busy), .done(done), .underrun_cnt(underrun_cnt), .fill_words(fill_words)
    );

    int errors = 0;
    int checks = 0;

    logic        s_req, s_ack, s_acc, s_ready, s_wr, s_rd, s_arstn, s_sv, s_done, s_busy;
    logic [31:0] s_addr;
    logic [9:0]  s_fill;
    logic [11:0] s_hi, s_lo;
    logic [15:0] s_under;
    logic [7:0]  s_data;

    logic        src_en = 1'b1;
    logic        sd_active = 1'b0;
    int          sd_cnt = 0;
    int          nreq, nblkdone, nacc, nsv, ndone, viol, nrd;
    logic [31:0] last_addr;
    logic [23:0] mem [512];
    logic [23:0] sh = '0;
    int          bcnt = 0, wp = 0, rp = 0;
    logic        cpend = 1'b0;
    logic [11:0] first_hi, first_lo, second_hi, second_lo;

    task automatic clr_counters();
        nreq = 0; nblkdone = 0; nacc = 0; nsv = 0; ndone = 0; viol = 0; nrd = 0;
        last_addr = '0;
        first_hi = 'x; first_lo = 'x; second_hi = 'x; second_lo = 'x;
    endtask

    // One clock: snapshot DUT at the falling edge, then advance the reader and buffer models.
    task automatic step();
        @(negedge clk);
        s_req = sd_rd_req; s_ack = sd_rd_ack; s_addr = sd_rd_addr;
        s_acc = sd_byte_valid & sd_byte_ready; s_ready = sd_byte_ready;
        s_wr = acc_wr_en; s_rd = acc_rd; s_fill = fill_words; s_arstn = acc_resetn;
        s_sv = sample_valid; s_hi = sample_hi; s_lo = sample_lo; s_done = done;
        s_busy = busy; s_under = underrun_cnt; s_data = acc_data;
        if (s_sv) begin
            if (nsv == 0) begin first_hi = s_hi; first_lo = s_lo; end
            if (nsv == 1) begin second_hi = s_hi; second_lo = s_lo; end
            nsv++;
        end
        if (s_done) ndone++;
        if (s_rd) nrd++;
        if (s_rd && s_fill == 10'd0) viol++;
        if (s_rd && s_wr) viol++;
        if (cpend && s_wr) viol++;
        if (s_wr !== s_acc) viol++;

        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; sample_tick = 1'b0;
        sd_rd_ack = 1'b0; sd_rd_done = 1'b0;
        if (s_acc) begin
            nacc++;
            sd_cnt++;
            if (sd_cnt == 512) begin
                sd_active = 1'b0;
                sd_rd_done = 1'b1;
                nblkdone++;
            end
        end
        if (s_req && s_ack) begin
            sd_active = 1'b1; sd_cnt = 0; last_addr = s_addr; nreq++;
        end else if (s_req) begin
            sd_rd_ack = 1'b1;
        end
        sd_byte_valid = sd_active & src_en;
        sd_byte = 8'(sd_cnt);

        if (!s_arstn) begin
            wp = 0; rp = 0; bcnt = 0; cpend = 1'b0;
        end else begin
            if (cpend) begin mem[wp % 512] = sh; wp++; cpend = 1'b0; end
            if (s_wr) begin
                sh = {sh[15:0], s_data};
                bcnt++;
                if (bcnt == 3) begin bcnt = 0; cpend = 1'b1; end
            end
            if (s_rd) begin acc_data_out = mem[rp % 512]; rp++; end
        end
    endtask

    task automatic abort_run();
        stop = 1'b1;
        repeat (4) step();
        sd_active = 1'b0; sd_byte_valid = 1'b0; src_en = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", s_req); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", s_busy); end
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", s_done); end
        checks++; if (s_sv !== 1'b0) begin errors++; $display("FAIL reset_sv: got %0b expected 0", s_sv); end
        checks++; if (s_fill !== 10'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", s_fill); end
        checks++; if (s_under !== 16'd0) begin errors++; $display("FAIL reset_under: got %0d expected 0", s_under); end
        checks++; if (s_arstn !== 1'b0) begin errors++; $display("FAIL reset_acc_resetn: got %0b expected 0", s_arstn); end
        checks++; if ({s_hi, s_lo} !== 24'h0) begin errors++; $display("FAIL reset_sample: got %0h expected 0", {s_hi, s_lo}); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b expected 0", s_ready); end
        resetn = 1'b1;
        step();
        checks++; if (s_arstn !== 1'b1) begin errors++; $display("FAIL run_acc_resetn: got %0b expected 1", s_arstn); end
    endtask

    task automatic test_single_block();
        int n;
        clr_counters();
        start_block = 32'h100; num_blocks = 32'd1; src_en = 1'b1;
        start = 1'b1;
        step();
        for (n = 0; n < 2000 && nblkdone < 1; n++) step();
        repeat (5) step();
        checks++; if (nblkdone !== 1) begin errors++; $display("FAIL single_blk_timeout: got %0d blocks expected 1", nblkdone); end
        checks++; if (last_addr !== 32'h100) begin errors++; $display("FAIL single_addr: got %0h expected 100", last_addr); end
        checks++; if (s_fill !== 10'd170) begin errors++; $display("FAIL single_fill: got %0d expected 170", s_fill); end
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b expected 1", s_busy); end
        for (int t = 0; t < 170; t++) begin
            sample_tick = 1'b1;
            repeat (4) step();
        end
        for (n = 0; n < 100 && ndone == 0; n++) step();
        checks++; if (ndone !== 1) begin errors++; $display("FAIL single_done: got %0d expected 1", ndone); end
        checks++; if (nsv !== 170) begin errors++; $display("FAIL single_samples: got %0d expected 170", nsv); end
        checks++; if ({first_hi, first_lo} !== 24'h000102) begin errors++; $display("FAIL single_first: got %0h expected 000102", {first_hi, first_lo}); end
        checks++; if ({second_hi, second_lo} !== 24'h030405) begin errors++; $display("FAIL single_second: got %0h expected 030405", {second_hi, second_lo}); end
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %0b expected 0", s_busy); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL single_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_zero_blocks();
        clr_counters();
        num_blocks = 32'd0;
        start = 1'b1;
        repeat (8) step();
        checks++; if (ndone !== 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", ndone); end
        checks++; if (nreq !== 0) begin errors++; $display("FAIL zero_req: got %0d expected 0", nreq); end
    endtask

    task automatic test_gap_rule();
        int n, bad;
        clr_counters();
        start_block = 32'h40; num_blocks = 32'd1;
        start = 1'b1;
        step();
        for (n = 0; n < 50 && !s_acc; n++) step();
        checks++; if (s_acc !== 1'b1) begin errors++; $display("FAIL gap_first_byte: got %0b expected 1", s_acc); end
        bad = 0;
        for (int k = 1; k < 40; k++) begin
            step();
            if (s_ready !== ((k % 4) != 3)) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL gap_pattern: got %0d bad cycles expected 0", bad); end
        step();
        checks++; if (s_fill !== 10'd10) begin errors++; $display("FAIL gap_fill40: got %0d expected 10", s_fill); end
        repeat (4) step();
        checks++; if (s_fill !== 10'd11) begin errors++; $display("FAIL gap_fill44: got %0d expected 11", s_fill); end
        abort_run();
    endtask

    task automatic test_collision();
        int n;
        clr_counters();
        start_block = 32'h0; num_blocks = 32'd1;
        start = 1'b1;
        step();
        for (n = 0; n < 100 && s_fill != 10'd5; n++) step();
        checks++; if (s_fill !== 10'd5) begin errors++; $display("FAIL coll_fill5: got %0d expected 5", s_fill); end
        sample_tick = 1'b1;
        step();
        checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL coll_rd_early: got %0b expected 0", s_rd); end
        step();
        checks++; if ({s_rd, s_ready} !== 2'b10) begin errors++; $display("FAIL coll_rd_ready: got %0b expected 10", {s_rd, s_ready}); end
        step();
        checks++; if (s_fill !== 10'd4) begin errors++; $display("FAIL coll_fill_dec: got %0d expected 4", s_fill); end
        checks++; if ({s_sv, s_ready} !== 2'b01) begin errors++; $display("FAIL coll_sv_early: got %0b expected 01", {s_sv, s_ready}); end
        step();
        checks++; if (s_sv !== 1'b1) begin errors++; $display("FAIL coll_sv: got %0b expected 1", s_sv); end
        checks++; if ({s_hi, s_lo} !== 24'h000102) begin errors++; $display("FAIL coll_data: got %0h expected 000102", {s_hi, s_lo}); end
        abort_run();
    endtask

    task automatic test_underrun();
        int n;
        clr_counters();
        src_en = 1'b0;
        start_block = 32'h0; num_blocks = 32'd1;
        start = 1'b1;
        repeat (6) step();
        for (int t = 0; t < 5; t++) begin
            sample_tick = 1'b1;
            step();
            step();
        end
        repeat (2) step();
        checks++; if (s_under !== 16'd4) begin errors++; $display("FAIL under_cnt: got %0d expected 4", s_under); end
        checks++; if (nrd !== 0) begin errors++; $display("FAIL under_reads: got %0d expected 0", nrd); end
        src_en = 1'b1;
        for (n = 0; n < 50 && nsv == 0; n++) step();
        checks++; if ({first_hi, first_lo} !== 24'h000102) begin errors++; $display("FAIL under_recover: got %0h expected 000102", {first_hi, first_lo}); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL under_protocol: got %0d violations expected 0", viol); end
        abort_run();
    endtask

    task automatic test_low_water();
        int n;
        clr_counters();
        start_block = 32'h2000; num_blocks = 32'd4;
        start = 1'b1;
        step();
        for (n = 0; n < 2000 && nblkdone < 2; n++) step();
        repeat (50) step();
        checks++; if (nreq !== 2) begin errors++; $display("FAIL lw_wait_req: got %0d expected 2", nreq); end
        checks++; if (s_fill !== 10'd341) begin errors++; $display("FAIL lw_fill: got %0d expected 341", s_fill); end
        for (int t = 0; t < 20; t++) begin
            sample_tick = 1'b1;
            repeat (3) step();
        end
        checks++; if ({s_fill, s_req} !== {10'd321, 1'b0}) begin errors++; $display("FAIL lw_above: got fill %0d req %0b expected 321 0", s_fill, s_req); end
        sample_tick = 1'b1;
        repeat (8) step();
        checks++; if (nreq !== 3) begin errors++; $display("FAIL lw_rereq: got %0d expected 3", nreq); end
        checks++; if (last_addr !== 32'h2002) begin errors++; $display("FAIL lw_addr: got %0h expected 2002", last_addr); end
        for (n = 0; n < 20000 && ndone == 0; n++) begin
            if (n % 3 == 0) sample_tick = 1'b1;
            step();
        end
        checks++; if (ndone !== 1) begin errors++; $display("FAIL lw_done: got %0d expected 1", ndone); end
        checks++; if (nsv !== 682) begin errors++; $display("FAIL lw_samples: got %0d expected 682", nsv); end
        checks++; if (nreq !== 4) begin errors++; $display("FAIL lw_reqs: got %0d expected 4", nreq); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL lw_protocol: got %0d violations expected 0", viol); end
    endtask

    task automatic test_stop();
        int n, lowcnt;
        clr_counters();
        start_block = 32'h10; num_blocks = 32'd2;
        start = 1'b1;
        step();
        for (n = 0; n < 400 && nacc < 200; n++) step();
        checks++; if (nacc !== 200) begin errors++; $display("FAIL stop_bytes: got %0d expected 200", nacc); end
        stop = 1'b1;
        lowcnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_arstn === 1'b0) lowcnt++;
        end
        checks++; if (lowcnt !== 1) begin errors++; $display("FAIL stop_flush_len: got %0d expected 1", lowcnt); end
        checks++; if (ndone !== 0) begin errors++; $display("FAIL stop_done: got %0d expected 0", ndone); end
        checks++; if ({s_busy, s_ready} !== 2'b00) begin errors++; $display("FAIL stop_idle: got %0b expected 00", {s_busy, s_ready}); end
        checks++; if (s_fill !== 10'd0) begin errors++; $display("FAIL stop_fill: got %0d expected 0", s_fill); end
        sd_active = 1'b0; sd_byte_valid = 1'b0;
    endtask

    initial begin
        clr_counters();
        test_reset();
        test_single_block();
        test_zero_blocks();
        test_gap_rule();
        test_collision();
        test_underrun();
        test_low_water();
        test_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
